// File: rtl/updn_mod_counter.sv
// Up/down event counter with programmable modulus and step size.
// Wrap or saturate at the boundaries, with sticky crossing flags.
module updn_mod_counter #(
    parameter int WIDTH  = 8,
    parameter int STEP_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              dn,
    input  logic              sat,
    input  logic              load,
    input  logic              clr,
    input  logic [WIDTH-1:0]  data,
    input  logic [WIDTH-1:0]  max_val,
    input  logic [STEP_W-1:0] step,
    output logic [WIDTH-1:0]  count,
    output logic              tc,
    output logic              ovf,
    output logic              unf,
    output logic              at_max,
    output logic              at_zero
);

    // Wide enough for count + step and count + max_val + 1 without loss.
    localparam int EW = ((WIDTH > STEP_W) ? WIDTH : STEP_W) + 1;

    logic [WIDTH-1:0] count_q, count_d;
    logic             tc_q, tc_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;

    logic [EW-1:0] cnt_e;
    logic [EW-1:0] max_e;
    logic [EW-1:0] step_e;
    logic [EW-1:0] s_e;
    logic [EW-1:0] sum_e;
    logic [EW-1:0] wrap_up_e;
    logic [EW-1:0] wrap_dn_e;

    always_comb begin
        cnt_e     = EW'(count_q);
        max_e     = EW'(max_val);
        step_e    = EW'(step);
        s_e       = (step_e > max_e) ? max_e : step_e;
        sum_e     = cnt_e + s_e;
        wrap_up_e = sum_e - max_e - EW'(1);
        wrap_dn_e = cnt_e + max_e + EW'(1) - s_e;
    end

    always_comb begin
        count_d = count_q;
        tc_d    = 1'b0;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        if (clr) begin
            count_d = '0;
            ovf_d   = 1'b0;
            unf_d   = 1'b0;
        end else if (load) begin
            count_d = (data > max_val) ? max_val : data;
        end else if (en && (s_e != '0)) begin
            if (cnt_e > max_e) begin
                // Modulus shrank below the count: recover as an up-crossing.
                count_d = sat ? max_val : '0;
                tc_d    = 1'b1;
                ovf_d   = 1'b1;
            end else if (!dn) begin
                if (sum_e > max_e) begin
                    count_d = sat ? max_val : WIDTH'(wrap_up_e);
                    tc_d    = 1'b1;
                    ovf_d   = 1'b1;
                end else begin
                    count_d = WIDTH'(sum_e);
                end
            end else begin
                if (cnt_e < s_e) begin
                    count_d = sat ? '0 : WIDTH'(wrap_dn_e);
                    tc_d    = 1'b1;
                    unf_d   = 1'b1;
                end else begin
                    count_d = WIDTH'(cnt_e - s_e);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
            tc_q    <= 1'b0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            tc_q    <= tc_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    assign count   = count_q;
    assign tc      = tc_q;
    assign ovf     = ovf_q;
    assign unf     = unf_q;
    assign at_max  = (count_q == max_val);
    assign at_zero = (count_q == '0);

endmodule
